// File: rtl/shift_arbiter.sv
// shift_arbiter: round-robin arbiter that shares one barrel-shift datapath
// between two requesters (port 0 ALU issue, port 1 multdiv/aux).
// The winner's operands are latched on grant. The shift runs from those
// latched copies, and a tagged result is returned as a registered value.
// Optional feature macro: SHIFT_ROTATE_EN. When it is defined, op 2'b11 is a
// rotate right that takes one extra ROT2 cycle. When it is not defined,
// op 2'b11 passes the operand through unchanged.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | no operation in flight, waiting for a request
// EXEC  | grant pulse; shifters run from the latched operands
// ROT2  | rotate only: OR the wrapped-around bits into the first half
// DONE  | result valid; the same edge may accept the next request
module shift_arbiter #(
   parameter int DATA_W  = 32,
   parameter int SHAMT_W = 5
) (
   input  logic               clock_i,
   input  logic               reset_i,
   input  logic               req0_i,
   input  logic               req1_i,
   input  logic [1:0]         op0_i,
   input  logic [1:0]         op1_i,
   input  logic [DATA_W-1:0]  data0_i,
   input  logic [DATA_W-1:0]  data1_i,
   input  logic [SHAMT_W-1:0] shamt0_i,
   input  logic [SHAMT_W-1:0] shamt1_i,
   output logic               gnt0_o,
   output logic               gnt1_o,
   output logic               busy_o,
   output logic               valid_out_o,
   output logic               id_out_o,
   output logic [DATA_W-1:0]  result_o
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      DONE = 2'd2
`ifdef SHIFT_ROTATE_EN
      , ROT2 = 2'd3
`endif
   } state_t;

   localparam logic [1:0] OP_SLL = 2'b00;
   localparam logic [1:0] OP_SRL = 2'b01;
   localparam logic [1:0] OP_SRA = 2'b10;

   state_t             state_q, state_d;
   logic               rr_last_q;
   logic [1:0]         op_q;
   logic [DATA_W-1:0]  data_q;
   logic [SHAMT_W-1:0] shamt_q;
   logic               id_q;
   logic [DATA_W-1:0]  result_q;
   logic               res_id_q;

   logic               any_req;
   logic               win_id;
   logic               take;
   logic               is_ror;
   logic [DATA_W-1:0]  shift_res;

   assign any_req = req0_i | req1_i;
   // A tie goes to the port that did not win last time. A lone request
   // always wins.
   assign win_id  = (req0_i & req1_i) ? ~rr_last_q : req1_i;

`ifdef SHIFT_ROTATE_EN
   logic [DATA_W-1:0]  temp_q;
   logic [SHAMT_W-1:0] rot_amt;
   logic [DATA_W-1:0]  rot_left;

   assign is_ror   = (op_q == 2'b11);
   // Rotating left by (DATA_W - s) mod DATA_W brings back the bits that the
   // right shift dropped. When s is 0 this is a shift by 0, so the OR gives x.
   assign rot_amt  = {SHAMT_W{1'b0}} - shamt_q;
   assign rot_left = data_q << rot_amt;
`else
   assign is_ror   = 1'b0;
`endif

   // Next-state logic. It also decides when the operands of a new winner are captured.
   always_comb begin
      state_d = state_q;
      take    = 1'b0;
      case (state_q)
         IDLE: begin
            if (any_req) begin
               take    = 1'b1;
               state_d = EXEC;
            end
         end
         EXEC: begin
`ifdef SHIFT_ROTATE_EN
            if (is_ror) state_d = ROT2;
            else        state_d = DONE;
`else
            state_d = DONE;
`endif
         end
`ifdef SHIFT_ROTATE_EN
         ROT2: state_d = DONE;
`endif
         DONE: begin
            if (any_req) begin
               take    = 1'b1;
               state_d = EXEC;
            end else begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Shift datapath, driven only from the latched operands.
   always_comb begin
      shift_res = data_q;
      case (op_q)
         OP_SLL:  shift_res = data_q << shamt_q;
         OP_SRL:  shift_res = data_q >> shamt_q;
         OP_SRA:  shift_res = $signed(data_q) >>> shamt_q;
         default: shift_res = data_q;
      endcase
   end

   // State register and round-robin pointer. rr_last resets to 1 so that
   // port 0 wins the first tie.
   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         state_q   <= IDLE;
         rr_last_q <= 1'b1;
      end else begin
         state_q <= state_d;
         if (take) rr_last_q <= win_id;
      end
   end

   // Capture the operands of the winning port on grant.
   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         op_q    <= 2'b00;
         data_q  <= '0;
         shamt_q <= '0;
         id_q    <= 1'b0;
      end else if (take) begin
         op_q    <= win_id ? op1_i    : op0_i;
         data_q  <= win_id ? data1_i  : data0_i;
         shamt_q <= win_id ? shamt1_i : shamt0_i;
         id_q    <= win_id;
      end
   end

   // Result and owner tag. Both are held until the next operation completes.
   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         result_q <= '0;
         res_id_q <= 1'b0;
`ifdef SHIFT_ROTATE_EN
         temp_q   <= '0;
`endif
      end else begin
         if (state_q == EXEC && !is_ror) begin
            result_q <= shift_res;
            res_id_q <= id_q;
         end
`ifdef SHIFT_ROTATE_EN
         if (state_q == EXEC && is_ror) temp_q <= data_q >> shamt_q;
         if (state_q == ROT2) begin
            result_q <= temp_q | rot_left;
            res_id_q <= id_q;
         end
`endif
      end
   end

   assign gnt0_o      = (state_q == EXEC) && !id_q;
   assign gnt1_o      = (state_q == EXEC) &&  id_q;
   assign busy_o      = (state_q != IDLE);
   assign valid_out_o = (state_q == DONE);
   assign id_out_o    = res_id_q;
   assign result_o    = result_q;

endmodule

// File: tb/tb_shift_arbiter.sv
// Testbench for shift_arbiter. It runs directed vectors first and then two
// random requesters checked against a scoreboard. SHIFT_ROTATE_EN selects
// the rotate expectations.
module tb_shift_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        req0, req1;
   logic [1:0]  op0, op1;
   logic [31:0] data0, data1;
   logic [4:0]  shamt0, shamt1;
   logic        gnt0, gnt1, busy, valid, id_out;
   logic [31:0] result;

   int n_chk  = 0;
   int n_pass = 0;

   typedef struct {
      logic [1:0]  op;
      logic [31:0] d;
      logic [4:0]  s;
   } op_t;

   typedef struct {
      logic        id;
      logic [31:0] r;
      int          due;
   } exp_t;

   op_t  q0[$];
   op_t  q1[$];
   exp_t exp_q[$];

   shift_arbiter #(.DATA_W(32), .SHAMT_W(5)) dut (
      .clock_i(clk), .reset_i(rst),
      .req0_i(req0), .req1_i(req1),
      .op0_i(op0), .op1_i(op1),
      .data0_i(data0), .data1_i(data1),
      .shamt0_i(shamt0), .shamt1_i(shamt1),
      .gnt0_o(gnt0), .gnt1_o(gnt1), .busy_o(busy),
      .valid_out_o(valid), .id_out_o(id_out), .result_o(result)
   );

   always #5 clk = ~clk;

`ifdef SHIFT_ROTATE_EN
   localparam bit ROT = 1'b1;
`else
   localparam bit ROT = 1'b0;
`endif

   // Reference model: builds each result bit from the operand bit it comes from.
   function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] d,
                                         input logic [4:0] s);
      logic [31:0] r;
      int sh;
      sh = int'(s);
      r = d;
      for (int i = 0; i < 32; i++) begin
         case (op)
            2'd0: r[i] = (i >= sh) ? d[i - sh] : 1'b0;
            2'd1: r[i] = (i + sh < 32) ? d[i + sh] : 1'b0;
            2'd2: r[i] = (i + sh < 32) ? d[i + sh] : d[31];
            default: r[i] = ROT ? d[(i + sh) % 32] : d[i];
         endcase
      end
      return r;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else begin
         $display("FAIL %s: observed %h expected %h", tag, obs, exp);
         $error("check %s", tag);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One directed transaction. The DUT is idle at entry, and the entry time
   // is just after a rising edge.
   task automatic do_op(input bit port, input logic [1:0] op, input logic [31:0] d,
                        input logic [4:0] s, input logic [31:0] exp_r, input string tag);
      if (port) begin req1 = 1'b1; op1 = op; data1 = d; shamt1 = s; end
      else      begin req0 = 1'b1; op0 = op; data0 = d; shamt0 = s; end
      tick();
      chk({tag, "_gnt0"}, 32'(gnt0), 32'(!port));
      chk({tag, "_gnt1"}, 32'(gnt1), 32'(port));
      chk({tag, "_busy"}, 32'(busy), 32'd1);
      req0 = 1'b0; req1 = 1'b0;
      tick();
      if (ROT && op == 2'b11) begin
         chk({tag, "_novalid_rot2"}, 32'(valid), 32'd0);
         tick();
      end
      chk({tag, "_valid"}, 32'(valid), 32'd1);
      chk({tag, "_id"}, 32'(id_out), 32'(port));
      chk({tag, "_result"}, result, exp_r);
      tick();
      chk({tag, "_idle_valid"}, 32'(valid), 32'd0);
      chk({tag, "_idle_busy"}, 32'(busy), 32'd0);
   endtask

   initial begin
      automatic logic        g;
      automatic logic        ew;
      automatic logic        last_win = 1'b1;
      automatic logic        hold_res;
      automatic logic [31:0] exp_pair [2];
      automatic op_t         o;
      automatic exp_t        e;
      automatic int          cyc;

      rst = 1'b1; req0 = 0; req1 = 0; op0 = 0; op1 = 0;
      data0 = 0; data1 = 0; shamt0 = 0; shamt1 = 0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_gnt0", 32'(gnt0), 0);
      chk("rst_gnt1", 32'(gnt1), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_valid", 32'(valid), 0);
      chk("rst_id", 32'(id_out), 0);
      chk("rst_result", result, 0);
      @(negedge clk) rst = 1'b0;
      tick();
      chk("idle_busy", 32'(busy), 0);

      // Spec vectors
      do_op(1'b0, 2'b00, 32'h0000_0001, 5'd31, 32'h8000_0000, "sll31");
      do_op(1'b1, 2'b10, 32'h8000_0010, 5'd4,  32'hF800_0001, "sra4");
      do_op(1'b1, 2'b01, 32'h8000_0010, 5'd4,  32'h0800_0001, "srl4");
      do_op(1'b0, 2'b10, 32'h8765_4321, 5'd0,  32'h8765_4321, "sra0");
      do_op(1'b1, 2'b00, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF, "sll0");
      do_op(1'b0, 2'b10, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF, "sra31");
      do_op(1'b1, 2'b01, 32'h8000_0000, 5'd31, 32'h0000_0001, "srl31");
`ifdef SHIFT_ROTATE_EN
      do_op(1'b0, 2'b11, 32'h0000_00F1, 5'd4, 32'h1000_000F, "ror4");
      do_op(1'b1, 2'b11, 32'h0000_00F1, 5'd0, 32'h0000_00F1, "ror0");
      do_op(1'b0, 2'b11, 32'h8000_0001, 5'd31, 32'h0000_0003, "ror31");
`else
      do_op(1'b0, 2'b11, 32'h0000_00F1, 5'd4, 32'h0000_00F1, "op3_pass");
`endif

      // Assert reset in the middle of EXEC and keep req0 high through the release.
      req0 = 1'b1; op0 = 2'b00; data0 = 32'h0000_0003; shamt0 = 5'd2;
      tick();
      chk("rstx_gnt", 32'(gnt0), 1);
      #2 rst = 1'b1;
      #1;
      chk("rstx_gnt0", 32'(gnt0), 0);
      chk("rstx_busy", 32'(busy), 0);
      chk("rstx_valid", 32'(valid), 0);
      chk("rstx_result", result, 0);
      tick();
      chk("rstx_valid2", 32'(valid), 0);
      @(negedge clk) rst = 1'b0;
      tick();
      chk("rstx_regnt", 32'(gnt0), 1);
      req0 = 1'b0;
      tick();
      chk("rstx_valid3", 32'(valid), 1);
      chk("rstx_res", result, 32'h0000_000C);
      tick();

      // After a fresh reset, hold both requests high: grants must strictly alternate, starting with port 0.
      rst = 1'b1; #2 rst = 1'b0;
      req0 = 1'b1; op0 = 2'b00; data0 = 32'h0000_0101; shamt0 = 5'd3;
      req1 = 1'b1; op1 = 2'b10; data1 = 32'hF000_0000; shamt1 = 5'd8;
      exp_pair[0] = 32'h0000_0808;
      exp_pair[1] = 32'hFFF0_0000;
      for (int i = 0; i < 6; i++) begin
         tick();
         chk("alt_gnt0", 32'(gnt0), 32'(i % 2 == 0));
         chk("alt_gnt1", 32'(gnt1), 32'(i % 2 == 1));
         if (i == 5) begin req0 = 1'b0; req1 = 1'b0; end
         tick();
         chk("alt_valid", 32'(valid), 1);
         chk("alt_id", 32'(id_out), 32'(i % 2));
         chk("alt_result", result, exp_pair[i % 2]);
      end
      tick();
      chk("alt_idle", 32'(busy), 0);
      last_win = 1'b1;

      // Random traffic from both requesters, checked against the scoreboard.
      for (int i = 0; i < 25; i++) begin
         o.op = 2'($urandom_range(0, 3)); o.d = $urandom; o.s = 5'($urandom_range(0, 31));
         q0.push_back(o);
         o.op = 2'($urandom_range(0, 3)); o.d = $urandom; o.s = 5'($urandom_range(0, 31));
         q1.push_back(o);
      end
      cyc = 0;
      while (cyc < 2000 && (q0.size() > 0 || q1.size() > 0 || exp_q.size() > 0 || req0 || req1)) begin
         tick();
         cyc++;
         if (gnt0 || gnt1) begin
            chk("rnd_onegnt", 32'(gnt0 & gnt1), 0);
            g  = gnt1;
            ew = (req0 && req1) ? ~last_win : req1;
            chk("rnd_winner", 32'(g), 32'(ew));
            last_win = g;
            if (g) begin o = q1.pop_front(); req1 = 1'b0; end
            else   begin o = q0.pop_front(); req0 = 1'b0; end
            e.id  = g;
            e.r   = model(o.op, o.d, o.s);
            e.due = cyc + ((ROT && o.op == 2'b11) ? 2 : 1);
            exp_q.push_back(e);
         end
         if (valid) begin
            if (exp_q.size() == 0) chk("rnd_spurious_valid", 32'(valid), 0);
            else begin
               e = exp_q.pop_front();
               chk("rnd_due", cyc, e.due);
               chk("rnd_id", 32'(id_out), 32'(e.id));
               chk("rnd_result", result, e.r);
            end
         end else if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
            chk("rnd_missing_valid", 32'(valid), 1);
            void'(exp_q.pop_front());
         end
         hold_res = req0;
         if (!hold_res && q0.size() > 0 && $urandom_range(0, 3) != 0) begin
            req0 = 1'b1; op0 = q0[0].op; data0 = q0[0].d; shamt0 = q0[0].s;
         end
         hold_res = req1;
         if (!hold_res && q1.size() > 0 && $urandom_range(0, 3) != 0) begin
            req1 = 1'b1; op1 = q1[0].op; data1 = q1[0].d; shamt1 = q1[0].s;
         end
      end
      chk("rnd_drained", 32'(q0.size() + q1.size() + exp_q.size()), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
